// File: rtl/fuzzy_fuzzifier.sv
`default_nettype none
// ============================================================================
// Module   : fuzzy_fuzzifier
// Purpose  : Triangular N/Z/P fuzzifier for two crisp 8-bit operands, computed
//            serially through one shared arithmetic unit over six cycles.
// Revision : 1.0  initial release
// ============================================================================
module fuzzy_fuzzifier #(
   parameter int CENTER = 128,
   parameter int SHIFT  = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] x1,
   input  logic [7:0] x2,
   output logic       busy,
   output logic       valid,
   output logic       overrun,
   output logic [7:0] mu1_n,
   output logic [7:0] mu1_z,
   output logic [7:0] mu1_p,
   output logic [7:0] mu2_n,
   output logic [7:0] mu2_z,
   output logic [7:0] mu2_p
);

   localparam logic [8:0] C_CENTER = 9'(CENTER);
   localparam logic [2:0] C_LAST   = 3'd5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_start_d;
   logic [2:0]      r_idx;
   logic [7:0]      r_x1;
   logic [7:0]      r_x2;
   logic [5:0][7:0] r_shadow;

   logic            w_edge;
   logic [7:0]      w_op;
   logic [8:0]      w_d;
   logic            w_neg;
   logic [7:0]      w_a;
   logic [15:0]     w_m;
   logic            w_sat;
   logic [7:0]      w_mag;
   logic [7:0]      w_n;
   logic [7:0]      w_z;
   logic [7:0]      w_p;
   logic [7:0]      w_res;

   assign w_edge = start & ~r_start_d;

   // Shared unit: idx 0..2 works on x1, 3..5 on x2.
   always_comb begin
      w_op  = (r_idx < 3'd3) ? r_x1 : r_x2;
      w_d   = {1'b0, w_op} - C_CENTER;
      w_neg = w_d[8];
      w_a   = w_neg ? 8'(-w_d) : w_d[7:0];
      w_m   = 16'(w_a) << SHIFT;
      w_sat = (w_m >= 16'd255);
      w_mag = w_sat ? 8'd255 : w_m[7:0];
      w_n   = w_neg ? w_mag : 8'd0;
      w_p   = (!w_neg && (w_a != 8'd0)) ? w_mag : 8'd0;
      w_z   = w_sat ? 8'd0 : 8'(8'd255 - w_m[7:0]);
      case (r_idx)
         3'd0, 3'd3: w_res = w_n;
         3'd1, 3'd4: w_res = w_z;
         default:    w_res = w_p;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_start_d <= 1'b0;
         r_idx     <= 3'd0;
         r_x1      <= 8'd0;
         r_x2      <= 8'd0;
         r_shadow  <= '0;
         busy      <= 1'b0;
         valid     <= 1'b0;
         overrun   <= 1'b0;
         mu1_n     <= 8'd0;
         mu1_z     <= 8'd0;
         mu1_p     <= 8'd0;
         mu2_n     <= 8'd0;
         mu2_z     <= 8'd0;
         mu2_p     <= 8'd0;
      end else begin
         r_start_d <= start;
         valid     <= 1'b0;
         // busy is registered so it spans the accepting edge through DONE.
         busy      <= (r_state != IDLE) || w_edge;
         case (r_state)
            IDLE: begin
               if (w_edge) begin
                  r_x1    <= x1;
                  r_x2    <= x2;
                  r_idx   <= 3'd0;
                  r_state <= CALC;
               end
            end
            CALC: begin
               if (w_edge) overrun <= 1'b1;
               r_shadow[r_idx] <= w_res;
               r_idx           <= r_idx + 3'd1;
               if (r_idx == C_LAST) r_state <= DONE;
            end
            DONE: begin
               if (w_edge) overrun <= 1'b1;
               mu1_n   <= r_shadow[0];
               mu1_z   <= r_shadow[1];
               mu1_p   <= r_shadow[2];
               mu2_n   <= r_shadow[3];
               mu2_z   <= r_shadow[4];
               mu2_p   <= r_shadow[5];
               valid   <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire
